// File: rtl/instr_encoder_loader_if.sv
// Symbolic-instruction handshake between a program source and the encoder/loader.
// The source drives the instruction fields; the loader answers with in_ready.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_sel;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles symbolic instructions into 32-bit MIPS words and writes them
// sequentially into instruction memory from address 0, one word per two cycles.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_loader_if.slave in_if,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_W:0]       word_count,
    output logic                  full,
    output logic                  done,
    output logic                  err_illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    // Returns {legal, word}; unused fields are forced to zero per instruction format.
    function automatic logic [32:0] encode(
        input logic [5:0]  sel,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [5:0]  fn;
        logic [5:0]  op;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [4:0]  f_sh;
        logic        legal;
        logic [31:0] w;
        fn    = 6'b000000;
        op    = 6'b000000;
        f_rs  = rs;
        f_rt  = rt;
        f_rd  = rd;
        f_sh  = 5'd0;
        legal = 1'b1;
        w     = 32'd0;

        case (sel)
            6'd1:  fn = 6'b100000;
            6'd2:  fn = 6'b100001;
            6'd3:  fn = 6'b100010;
            6'd4:  fn = 6'b100011;
            6'd5:  fn = 6'b100100;
            6'd6:  fn = 6'b100101;
            6'd7:  fn = 6'b100110;
            6'd8:  fn = 6'b100111;
            6'd9:  fn = 6'b101010;
            6'd10: fn = 6'b101011;
            6'd11: fn = 6'b000000;
            6'd12: fn = 6'b000010;
            6'd13: fn = 6'b000011;
            6'd14: fn = 6'b000100;
            6'd15: fn = 6'b000110;
            6'd16: fn = 6'b000111;
            6'd17: fn = 6'b001000;
            6'd18: fn = 6'b000010;
            default: fn = 6'b000000;
        endcase

        case (sel)
            6'd18: op = 6'b011100;
            6'd19: op = 6'b000100;
            6'd20: op = 6'b000101;
            6'd21: op = 6'b000001;
            6'd22: op = 6'b000001;
            6'd23: op = 6'b000111;
            6'd24: op = 6'b000110;
            6'd25: op = 6'b000010;
            6'd26: op = 6'b001000;
            6'd27: op = 6'b001001;
            6'd28: op = 6'b001100;
            6'd29: op = 6'b001101;
            6'd30: op = 6'b001110;
            6'd31: op = 6'b001010;
            6'd32: op = 6'b001011;
            6'd33: op = 6'b100011;
            6'd34: op = 6'b101011;
            default: op = 6'b000000;
        endcase

        if (sel == 6'd0) begin
            w = 32'd0;
        end else if (sel <= 6'd18) begin
            // Immediate shifts keep shamt and drop rs; JR keeps only rs.
            if (sel >= 6'd11 && sel <= 6'd13) begin
                f_sh = sh;
                f_rs = 5'd0;
            end
            if (sel == 6'd17) begin
                f_rt = 5'd0;
                f_rd = 5'd0;
            end
            w = {op, f_rs, f_rt, f_rd, f_sh, fn};
        end else if (sel == 6'd25) begin
            w = {op, tgt};
        end else if (sel <= 6'd34) begin
            // REGIMM branches select BGEZ/BLTZ through rt; BGTZ/BLEZ require rt=0.
            if (sel == 6'd21) begin
                f_rt = 5'd1;
            end else if (sel >= 6'd22 && sel <= 6'd24) begin
                f_rt = 5'd0;
            end
            w = {op, f_rs, f_rt, imm};
        end else begin
            legal = 1'b0;
        end
        return {legal, w};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_last;
    logic [ADDR_W:0]     r_count;
    logic                r_err;

    logic [32:0]         w_enc;
    logic                w_full;
    logic                w_ready;
    logic                w_we;
    logic                w_capture;
    logic                w_commit;
    logic                w_err_nxt;

    assign w_enc = encode(in_if.in_sel, in_if.in_rs, in_if.in_rt, in_if.in_rd,
                          in_if.in_shamt, in_if.in_imm, in_if.in_target);
    assign w_full = (r_count == CAP);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_we        = 1'b0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !w_full;
                if (in_if.in_valid && w_ready) begin
                    if (w_enc[32]) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_we        = 1'b1;
                w_commit    = 1'b1;
                w_state_nxt = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_capture) begin
                r_wdata <= w_enc[31:0];
                r_last  <= in_if.in_last;
            end
            if (w_commit) begin
                r_count <= r_count + 1'b1;
                // The word that fills memory leaves the address on the last slot.
                if (r_count != CAP - 1'b1) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign in_if.in_ready = w_ready;
    assign imem_we        = w_we;
    assign imem_addr      = r_addr;
    assign imem_wdata     = r_wdata;
    assign word_count     = r_count;
    assign full           = w_full;
    assign done           = (r_state == S_DONE);
    assign err_illegal    = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed programs against a transaction-level
// model of the loader, plus hand-computed encodings and outcomes.
module tb_instr_encoder_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_loader_if bus ();

    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          done;
    logic          err_illegal;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .word_count  (word_count),
        .full        (full),
        .done        (done),
        .err_illegal (err_illegal)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Flat per-instruction encoding table: {legal, word}.
    function automatic logic [32:0] ref_encode(input int sel, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [15:0] imm, input logic [25:0] tgt);
        case (sel)
            0:  return {1'b1, 32'h0};
            1:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
            2:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h21};
            3:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
            4:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h23};
            5:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
            6:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
            7:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h26};
            8:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h27};
            9:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2a};
            10: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2b};
            11: return {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h00};
            12: return {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h02};
            13: return {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h03};
            14: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h04};
            15: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h06};
            16: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h07};
            17: return {1'b1, 6'h00, rs, 15'd0, 6'h08};
            18: return {1'b1, 6'h1c, rs, rt, rd, 5'd0, 6'h02};
            19: return {1'b1, 6'h04, rs, rt, imm};
            20: return {1'b1, 6'h05, rs, rt, imm};
            21: return {1'b1, 6'h01, rs, 5'd1, imm};
            22: return {1'b1, 6'h01, rs, 5'd0, imm};
            23: return {1'b1, 6'h07, rs, 5'd0, imm};
            24: return {1'b1, 6'h06, rs, 5'd0, imm};
            25: return {1'b1, 6'h02, tgt};
            26: return {1'b1, 6'h08, rs, rt, imm};
            27: return {1'b1, 6'h09, rs, rt, imm};
            28: return {1'b1, 6'h0c, rs, rt, imm};
            29: return {1'b1, 6'h0d, rs, rt, imm};
            30: return {1'b1, 6'h0e, rs, rt, imm};
            31: return {1'b1, 6'h0a, rs, rt, imm};
            32: return {1'b1, 6'h0b, rs, rt, imm};
            33: return {1'b1, 6'h23, rs, rt, imm};
            34: return {1'b1, 6'h2b, rs, rt, imm};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    // Transaction-level model: a word accepted in one cycle is written in the next.
    int          m_count = 0;
    int          m_addr  = 0;
    logic [31:0] m_word  = 32'h0;
    bit          m_busy  = 1'b0;
    bit          m_plast = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;

    always @(posedge clk) begin
        logic [32:0] enc;
        if (reset) begin
            m_count = 0;
            m_addr  = 0;
            m_word  = 32'h0;
            m_busy  = 1'b0;
            m_plast = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_busy) begin
                m_busy = 1'b0;
                m_count++;
                if (m_count < CAP) m_addr++;
                if (m_plast) m_done = 1'b1;
            end else if (bus.in_valid && !m_done && m_count < CAP) begin
                enc = ref_encode(int'(bus.in_sel), bus.in_rs, bus.in_rt, bus.in_rd,
                                 bus.in_shamt, bus.in_imm, bus.in_target);
                if (enc[32]) begin
                    m_word  = enc[31:0];
                    m_plast = bus.in_last;
                    m_busy  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    bit          cmp_en   = 1'b0;
    int          n_writes = 0;
    int          n_errs   = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("we",    32'(imem_we), 32'(m_busy));
            chk("ready", 32'(bus.in_ready), 32'(!m_busy && !m_done && m_count < CAP));
            chk("count", 32'(word_count), m_count);
            chk("full",  32'(full), 32'(m_count == CAP));
            chk("done",  32'(done), 32'(m_done));
            chk("err",   32'(err_illegal), 32'(m_err));
            if (m_count < CAP) chk("addr", 32'(imem_addr), m_addr);
            if (m_busy) chk("wdata", imem_wdata, m_word);
            if (imem_we) begin
                n_writes++;
                last_wdata = imem_wdata;
                last_waddr = 32'(imem_addr);
            end
            if (err_illegal) n_errs++;
        end
    end

    task automatic send(input logic [5:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        bus.in_sel    = sel;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_shamt  = sh;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [32:0] e;
        int w0;
        int e0;
        bus.in_valid = 1'b0; bus.in_sel = 6'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_shamt = 5'd0; bus.in_imm = 16'd0; bus.in_target = 26'd0;
        bus.in_last = 1'b0;

        // Pin the model against hand-assembled words.
        e = ref_encode(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);    chk("model_add", e[31:0], 32'h00221820);
        e = ref_encode(11, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);   chk("model_sll", e[31:0], 32'h00031100);
        e = ref_encode(21, 5'd4, 5'd9, 5'd0, 5'd0, 16'h3, 26'h0);   chk("model_bgez", e[31:0], 32'h04810003);
        e = ref_encode(18, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 26'h0);   chk("model_mul", e[31:0], 32'h70A62002);
        e = ref_encode(40, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);   chk("model_illegal", 32'(e[32]), 32'd0);

        @(posedge clk); #1;
        cmp_en = 1'b1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_flags", {29'd0, full, done, err_illegal}, 32'd0);
        reset = 1'b0;

        // ADD then ADDI.
        send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        chk("add_wdata", last_wdata, 32'h00221820);
        chk("add_addr",  last_waddr, 32'd0);
        send(6'd26, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        chk("addi_wdata", last_wdata, 32'h2005FFFF);
        chk("addi_addr",  last_waddr, 32'd1);
        chk("two_count",  32'(word_count), 32'd2);
        do_reset();

        // Field forcing; the four words fill memory, a fifth is ignored.
        send(6'd11, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
        chk("sll_wdata", last_wdata, 32'h00031100);
        send(6'd21, 5'd4, 5'd9, 5'd0, 5'd0, 16'h3, 26'h0, 1'b0);
        chk("bgez_wdata", last_wdata, 32'h04810003);
        send(6'd18, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0);
        chk("mul_wdata", last_wdata, 32'h70A62002);
        send(6'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0);
        chk("j_wdata", last_wdata, 32'h08000010);
        chk("j_addr",  last_waddr, 32'd3);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_count", 32'(word_count), 32'd4);
        chk("fill_ready", 32'(bus.in_ready), 32'd0);
        w0 = n_writes;
        send(6'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
        chk("fifth_ignored", 32'(n_writes), 32'(w0));
        do_reset();

        // Last word then done; further input ignored.
        send(6'd33, 5'd29, 5'd8, 5'd0, 5'd0, 16'h4, 26'h0, 1'b1);
        chk("lw_wdata", last_wdata, 32'h8FA80004);
        chk("lw_done",  32'(done), 32'd1);
        chk("lw_ready", 32'(bus.in_ready), 32'd0);
        w0 = n_writes;
        send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        chk("after_done_ignored", 32'(n_writes), 32'(w0));
        do_reset();

        // Illegal code (with in_last set) is dropped, then fill with last on the final word.
        w0 = n_writes;
        e0 = n_errs;
        send(6'd40, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        chk("illegal_nowrite", 32'(n_writes), 32'(w0));
        chk("illegal_pulse",   32'(n_errs), 32'(e0 + 1));
        chk("illegal_notdone", 32'(done), 32'd0);
        send(6'd29, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00F0, 26'h0, 1'b0);
        chk("ori_wdata", last_wdata, 32'h342200F0);
        chk("ori_addr",  last_waddr, 32'd0);
        send(6'd16, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 1'b0);
        chk("srav_wdata", last_wdata, 32'h00221807);
        send(6'd24, 5'd3, 5'd7, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0);
        chk("blez_wdata", last_wdata, 32'h1860FFFE);
        send(6'd17, 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        chk("jr_wdata", last_wdata, 32'h03E00008);
        chk("last_fill_done", 32'(done), 32'd1);
        chk("last_fill_full", 32'(full), 32'd1);
        do_reset();

        // Reset during WRITE abandons the write.
        bus.in_sel = 6'd1; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
        bus.in_last = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstw_we",    32'(imem_we), 32'd0);
        chk("rstw_addr",  32'(imem_addr), 32'd0);
        chk("rstw_count", 32'(word_count), 32'd0);
        chk("rstw_ready", 32'(bus.in_ready), 32'd1);
        send(6'd34, 5'd2, 5'd3, 5'd0, 5'd0, 16'h8, 26'h0, 1'b0);
        chk("sw_wdata", last_wdata, 32'hAC430008);
        chk("sw_addr",  last_waddr, 32'd0);

        // Valid held high: one word per two cycles.
        w0 = n_writes;
        bus.in_sel = 6'd30; bus.in_rs = 5'd1; bus.in_rt = 5'd1; bus.in_imm = 16'h1;
        bus.in_last = 1'b0; bus.in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("burst_writes", 32'(n_writes), 32'(w0 + 2));
        chk("burst_wdata",  last_wdata, 32'h38210001);
        chk("burst_count",  32'(word_count), 32'd3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encoder-side counterpart of the pipeline's instruction decoder. It accepts symbolic instructions (instruction select code plus register, immediate and target fields) over a valid/ready handshake and assembles each one into a 32-bit MIPS word. Each word is written sequentially into instruction memory from address 0. It sits in front of the instruction memory write port and is used to load programs before and between CPU runs.

## Interface
Parameters:
- ADDR_W, 8: instruction memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  a symbolic instruction is presented.
- in_ready  out  1  the loader can accept an instruction this cycle.
- in_sel  in  6  instruction select code (see Operation).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  I-type immediate or branch offset, taken raw.
- in_target  in  26  J-type target field.
- in_last  in  1  the accepted instruction is the final word of the program.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  number of words written since reset.
- full  out  1  capacity reached.
- done  out  1  the in_last word has been written.
- err_illegal  out  1  one-cycle pulse: an illegal select code was accepted and dropped.

## Operation
- Select codes:
  - 0 NOP
  - 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU
  - 11 SLL, 12 SRL, 13 SRA, 14 SLLV, 15 SRLV, 16 SRAV
  - 17 JR, 18 MUL
  - 19 BEQ, 20 BNE, 21 BGEZ, 22 BLTZ, 23 BGTZ, 24 BLEZ, 25 J
  - 26 ADDI, 27 ADDIU, 28 ANDI, 29 ORI, 30 XORI, 31 SLTI, 32 SLTIU
  - 33 LW, 34 SW
  - 35–63 are illegal.
- R-type words: op 000000, rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
  - funct: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000.
- Field forcing for R-type:
  - SLL/SRL/SRA: rs forced to 0.
  - All other R-type: shamt forced to 0.
  - JR: rt, rd and shamt forced to 0.
- MUL: op 011100, funct 000010, shamt 0.
- I-type words: op[31:26], rs, rt, imm[15:0].
  - op: BEQ 000100, BNE 000101, REGIMM 000001 (BGEZ rt=00001, BLTZ rt=00000, rt forced), BGTZ 000111, BLEZ 000110 (rt forced to 0 for both), ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011, LW 100011, SW 101011.
- J: op 000010, target[25:0].
- NOP: 32'h00000000.
- FSM states:
  - IDLE: in_ready = !full. On in_valid & in_ready, capture the encoded word and in_last, then go to WRITE.
  - If the accepted code is illegal: pulse err_illegal next cycle, stay in IDLE, no write, address unchanged, in_last ignored.
  - WRITE: imem_we=1 with the current address/data. Then word_count increments and the address increments.
    - If the captured in_last=1, go to DONE; otherwise go to IDLE.
  - DONE: in_ready=0, done=1. Holds until reset.
- full = (word_count == 2^ADDR_W). When full, in_ready=0 in IDLE. An address wrap never occurs.
- Reset values: state IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, full=0, done=0, err_illegal=0.

## Timing
- The handshake is accepted in cycle N. imem_we=1 in cycle N+1 with registered addr/wdata. in_ready returns high in N+2 unless full or done.
- Maximum throughput is one word per 2 cycles. in_ready is low throughout WRITE.
- imem_addr/imem_wdata are stable for the whole WRITE cycle. imem_addr advances on the WRITE-exit edge.
- word_count and full update on the same edge that ends WRITE.
- done rises in the cycle after the last-word WRITE.
- in_last on the word that fills memory: done and full both assert together.
- An illegal code is accepted in cycle N: err_illegal=1 in N+1 only, and in_ready stays 1.
- Reset asserted in any state (including WRITE) has the following effect at the next edge:
  - all outputs return to their reset values;
  - a pending write is abandoned;
  - imem_we is 0 in the cycle after.
- in_valid while in_ready=0 is ignored; inputs are not held internally.

## Test plan
- ADD rs=1 rt=2 rd=3 -> imem_we pulse, addr 0, wdata 0x00221820. Then ADDI rs=0 rt=5 imm=0xFFFF -> addr 1, wdata 0x2005FFFF. word_count=2.
- Field forcing:
  - SLL rs=7 rt=3 rd=2 shamt=4 -> 0x00031100 (rs dropped).
  - BGEZ rs=4 rt=9 imm=3 -> 0x04810003.
  - MUL rs=5 rt=6 rd=4 -> 0x70A62002.
  - J target=0x10 -> 0x08000010.
- LW rs=29 rt=8 imm=4 with in_last=1 -> wdata 0x8FA80004, then done=1 and in_ready=0. A following in_valid produces no write.
- Illegal sel=40 -> no imem_we, err_illegal high exactly one cycle, and the next legal word is written at the unchanged address.
- ADDR_W=2: four legal words -> addresses 0–3 written, full=1, word_count=4, in_ready=0. A fifth in_valid is ignored.
- Reset asserted during WRITE -> next cycle imem_we=0, addr 0, word_count 0, in_ready 1. A subsequent word is written to addr 0.
